// File: rtl/sdc_arbiter.sv
// Two-port arbiter for the SDRAM controller command port (CPU via mmu, DMA stream fetch).
// Define SDC_ARB_ROUND_ROBIN_EN to alternate the winner on contention instead of fixed CPU priority.
module sdc_arbiter #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              sdc_cs,
    output logic              sdc_rd,
    output logic              sdc_wr,
    output logic [ADDR_W-1:0] sdc_addr,
    output logic [DATA_W-1:0] sdc_data_in,
    input  logic [DATA_W-1:0] sdc_data_out,
    input  logic              sdc_busy,
    output logic              grant
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, ACK} state_t;

    state_t            state, state_nx;
    logic              we_q, we_nx;
    logic              pick_dma, win_we;
    logic              cs_nx, rd_nx, wr_nx, cpu_ack_nx, dma_ack_nx, grant_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] wdata_nx, cpu_rdata_nx, dma_rdata_nx;

`ifdef SDC_ARB_ROUND_ROBIN_EN
    // On contention the port that did not own the last access wins.
    assign pick_dma = dma_req & (~cpu_req | ~grant);
`else
    assign pick_dma = dma_req & ~cpu_req;
`endif
    assign win_we = pick_dma ? dma_we : cpu_we;

    always_comb begin
        state_nx     = state;
        we_nx        = we_q;
        cs_nx        = 1'b0;
        rd_nx        = 1'b0;
        wr_nx        = 1'b0;
        cpu_ack_nx   = 1'b0;
        dma_ack_nx   = 1'b0;
        grant_nx     = grant;
        addr_nx      = sdc_addr;
        wdata_nx     = sdc_data_in;
        cpu_rdata_nx = cpu_rdata;
        dma_rdata_nx = dma_rdata;
        case (state)
            IDLE: begin
                if ((cpu_req | dma_req) && !sdc_busy) begin
                    grant_nx = pick_dma;
                    addr_nx  = pick_dma ? dma_addr : cpu_addr;
                    wdata_nx = pick_dma ? dma_wdata : cpu_wdata;
                    we_nx    = win_we;
                    // Strobes are registered, so they are raised here to be high during ISSUE.
                    cs_nx    = 1'b1;
                    rd_nx    = ~win_we;
                    wr_nx    = win_we;
                    state_nx = ISSUE;
                end
            end
            ISSUE: state_nx = WAIT_HI;
            WAIT_HI: begin
                if (sdc_busy) state_nx = WAIT_LO;
            end
            WAIT_LO: begin
                if (!sdc_busy) begin
                    if (!we_q) begin
                        if (grant) dma_rdata_nx = sdc_data_out;
                        else       cpu_rdata_nx = sdc_data_out;
                    end
                    cpu_ack_nx = ~grant;
                    dma_ack_nx = grant;
                    state_nx   = ACK;
                end
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            sdc_cs      <= 1'b0;
            sdc_rd      <= 1'b0;
            sdc_wr      <= 1'b0;
            cpu_ack     <= 1'b0;
            dma_ack     <= 1'b0;
            grant       <= 1'b0;
            sdc_addr    <= '0;
            sdc_data_in <= '0;
            cpu_rdata   <= '0;
            dma_rdata   <= '0;
        end else begin
            state       <= state_nx;
            we_q        <= we_nx;
            sdc_cs      <= cs_nx;
            sdc_rd      <= rd_nx;
            sdc_wr      <= wr_nx;
            cpu_ack     <= cpu_ack_nx;
            dma_ack     <= dma_ack_nx;
            grant       <= grant_nx;
            sdc_addr    <= addr_nx;
            sdc_data_in <= wdata_nx;
            cpu_rdata   <= cpu_rdata_nx;
            dma_rdata   <= dma_rdata_nx;
        end
    end

endmodule

// File: tb/tb_sdc_arbiter.sv
// Bench for sdc_arbiter: directed and random requests, a controller responder and a scoreboard.
module tb_sdc_arbiter;
    localparam int AW = 25;
    localparam int DW = 32;

    logic          clk, reset;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr, sdc_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata;
    logic          cpu_ack, dma_ack, grant;
    logic          sdc_cs, sdc_rd, sdc_wr, sdc_busy;
    logic [DW-1:0] sdc_data_in, sdc_data_out;

    int cyc = 0, checks = 0, errors = 0, timeouts = 0;
    int fixed_b = 0, pre_busy_until = 0;
    bit done = 0;
    logic [DW-1:0] fixed_data = '0;

    typedef struct {
        logic          port;
        logic          rd;
        logic [DW-1:0] data;
    } exp_t;
    exp_t q[$];

    sdc_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .sdc_cs(sdc_cs), .sdc_rd(sdc_rd), .sdc_wr(sdc_wr), .sdc_addr(sdc_addr),
        .sdc_data_in(sdc_data_in), .sdc_data_out(sdc_data_out), .sdc_busy(sdc_busy),
        .grant(grant)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // Controller model: busy rises the cycle after cs and stays high B cycles.
    initial begin
        int  rem;
        bit  bc;
        rem = 0;
        sdc_busy = 0;
        sdc_data_out = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rem > 0) begin bc = 1; rem--; end
            else bc = 0;
            if (sdc_cs) begin
                rem = (fixed_b != 0) ? fixed_b : int'($urandom_range(1, 4));
                sdc_data_out = (fixed_b != 0) ? fixed_data : $urandom;
            end
            sdc_busy = bc || (cyc < pre_busy_until);
        end
    end

    // Reference model and scoreboard, sampled mid-cycle.
    initial begin
        logic          p_rst, p_busy, p_creq, p_dreq, p_cwe, p_dwe;
        logic [AW-1:0] p_caddr, p_daddr, exp_addr;
        logic [DW-1:0] p_cwd, p_dwd, exp_wdata, m_crd, m_drd;
        logic          m_idle, m_grant, in_flight, ack_due, next_due, exp_cs, win, wwe;
        logic [1:0]    exp_ackv;
        int            phase;
        exp_t          e;
        p_rst = 1; p_busy = 0; p_creq = 0; p_dreq = 0; p_cwe = 0; p_dwe = 0;
        p_caddr = '0; p_daddr = '0; p_cwd = '0; p_dwd = '0;
        exp_addr = '0; exp_wdata = '0; m_crd = '0; m_drd = '0;
        m_idle = 0; m_grant = 0; in_flight = 0; ack_due = 0; phase = 0;
        forever begin
            @(negedge clk);
            if (cyc > 30000) begin
                $display("FAIL watchdog: cycle %0d exceeded budget", cyc);
                $fatal(1, "watchdog");
            end
            if (done) begin
                chk("timeouts", 128'(timeouts), 128'(0));
                chk("pending_acks", 128'(q.size()), 128'(0));
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
            if (p_rst) begin
                chk("reset_outputs", 128'({sdc_cs, sdc_rd, sdc_wr, cpu_ack, dma_ack, grant,
                    sdc_addr, sdc_data_in, cpu_rdata, dma_rdata}), 128'(0));
                q.delete();
                in_flight = 0; ack_due = 0; phase = 0;
                m_grant = 0; m_crd = '0; m_drd = '0; m_idle = 1;
            end else begin
                exp_cs = m_idle && !p_busy && (p_creq || p_dreq);
`ifdef SDC_ARB_ROUND_ROBIN_EN
                win = p_dreq && (!p_creq || !m_grant);
`else
                win = p_dreq && !p_creq;
`endif
                wwe = win ? p_dwe : p_cwe;
                chk("strobes", 128'({sdc_cs, sdc_rd, sdc_wr}),
                    128'(exp_cs ? {1'b1, !wwe, wwe} : 3'b000));
                if (exp_cs) begin
                    chk("grant", 128'(grant), 128'(win));
                    m_grant   = win;
                    exp_addr  = win ? p_daddr : p_caddr;
                    exp_wdata = win ? p_dwd : p_cwd;
                    q.push_back('{port: win, rd: !wwe, data: sdc_data_out});
                    in_flight = 1;
                    phase = 0;
                end
                if (in_flight)
                    chk("addr_data_hold", 128'({sdc_addr, sdc_data_in}), 128'({exp_addr, exp_wdata}));
                exp_ackv = 2'b00;
                if (ack_due && q.size() > 0) exp_ackv = q[0].port ? 2'b01 : 2'b10;
                chk("ack", 128'({cpu_ack, dma_ack}), 128'(exp_ackv));
                if (ack_due && q.size() > 0 && (cpu_ack || dma_ack)) begin
                    e = q.pop_front();
                    if (e.rd) begin
                        if (e.port) m_drd = e.data;
                        else        m_crd = e.data;
                    end
                    chk("rdata", 128'({cpu_rdata, dma_rdata}), 128'({m_crd, m_drd}));
                    in_flight = 0;
                end
                // Ack is due the cycle after busy is first seen low following a busy-high cycle.
                next_due = 0;
                if (in_flight && !exp_cs) begin
                    if (phase == 0 && sdc_busy) phase = 1;
                    else if (phase == 1 && !sdc_busy) begin
                        phase = 2;
                        next_due = 1;
                    end
                end
                m_idle  = !in_flight && !ack_due;
                ack_due = next_due;
            end
            p_rst = reset; p_busy = sdc_busy;
            p_creq = cpu_req; p_dreq = dma_req; p_cwe = cpu_we; p_dwe = dma_we;
            p_caddr = cpu_addr; p_daddr = dma_addr; p_cwd = cpu_wdata; p_dwd = dma_wdata;
        end
    end

    task automatic serve(input bit c, input bit d, input bit tog);
        bit cp, dp, ca, da;
        cp = c; dp = d;
        cpu_req = c; dma_req = d;
        for (int k = 0; k < 400 && (cp || dp); k++) begin
            @(negedge clk);
            ca = cpu_ack; da = dma_ack;
            @(posedge clk);
            #1;
            if (tog && cp) begin
                cpu_req   = ~cpu_req;
                cpu_addr  = AW'($urandom);
                cpu_wdata = $urandom;
            end
            if (ca) begin cpu_req = 0; cp = 0; end
            if (da) begin dma_req = 0; dp = 0; end
        end
        if (cp || dp) begin
            timeouts++;
            cpu_req = 0; dma_req = 0;
        end
    endtask

    task automatic both_rounds(input int rounds);
        int n;
        n = 0;
        cpu_req = 1; dma_req = 1;
        for (int k = 0; k < 300 && n < rounds; k++) begin
            @(negedge clk);
            if (cpu_ack || dma_ack) n++;
            @(posedge clk);
            #1;
        end
        if (n < rounds) timeouts++;
        cpu_req = 0; dma_req = 0;
    endtask

    task automatic randomize_ports();
        cpu_we = 1'($urandom); cpu_addr = AW'($urandom); cpu_wdata = $urandom;
        dma_we = 1'($urandom); dma_addr = AW'($urandom); dma_wdata = $urandom;
    endtask

    initial begin
        bit         seen;
        logic [1:0] sel;
        reset = 1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 0;

        fixed_b = 3; fixed_data = 32'hDEADBEEF;
        cpu_we = 0; cpu_addr = 25'h0ABC123; cpu_wdata = 32'h0BAD0BAD;
        serve(1, 0, 0);

        fixed_b = 2;
        dma_we = 1; dma_addr = 25'h1FFFFFF; dma_wdata = 32'h12345678;
        serve(0, 1, 0);

        fixed_b = 0;
        randomize_ports();
        both_rounds(3);

        pre_busy_until = cyc + 5;
        cpu_we = 0; cpu_addr = 25'h0000155;
        serve(1, 0, 0);

        // Abort an access with reset while the controller is still busy.
        fixed_b = 8; fixed_data = 32'hCAFEF00D;
        cpu_we = 0; cpu_addr = 25'h0123456;
        cpu_req = 1;
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (sdc_cs) seen = 1;
        end
        if (!seen) timeouts++;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1; cpu_req = 0;
        @(posedge clk);
        #1 reset = 0;
        repeat (12) begin @(posedge clk); #1; end

        fixed_b = 20; fixed_data = 32'h55AA55AA;
        cpu_we = 1; cpu_addr = 25'h1A5A5A5; cpu_wdata = 32'hA5A5A5A5;
        serve(1, 0, 1);

        fixed_b = 0;
        repeat (60) begin
            randomize_ports();
            if ($urandom_range(0, 3) == 0) pre_busy_until = cyc + int'($urandom_range(1, 4));
            sel = 2'($urandom_range(1, 3));
            serve(sel[0], sel[1], 0);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        if ($urandom_range(0, 1) == 1) begin
            randomize_ports();
            both_rounds(4);
        end

        repeat (5) begin @(posedge clk); #1; end
        done = 1;
        forever @(posedge clk);
    end

endmodule

// File: doc/sdc_arbiter.md
Name: sdc_arbiter

Overview:
- Shares the single SDRAM controller command port between two requesters.
  - CPU port: the mmu output, with the 25-bit address already formed.
  - Stream port: step-buffer DMA fetch.
- Sequences each access as issue, wait busy high, wait busy low, ack, and captures read data.
- Sits between mmu/DMA and the SDRAM controller; it is the only driver of sdc_cs/sdc_rd/sdc_wr.

Parameters:
- ADDR_W, 25, SDRAM word address width.
- DATA_W, 32, SDRAM data width.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1=write, 0=read; stable while cpu_req
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid with cpu_ack, held until next CPU read
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata  same as the cpu_* set, for the stream port
- sdc_cs  out  1  command strobe to the controller
- sdc_rd  out  1  read command
- sdc_wr  out  1  write command
- sdc_addr  out  ADDR_W  command address
- sdc_data_in  out  DATA_W  write data to the controller
- sdc_data_out  in  DATA_W  read data from the controller
- sdc_busy  in  1  controller busy
- grant  out  1  current/last owner: 0=CPU, 1=DMA

Behaviour:
- Reset: reset, synchronous, active-high; clock clk.
  - Reset values: state=IDLE; all acks=0; sdc_cs/rd/wr=0; sdc_addr=0; sdc_data_in=0; cpu_rdata=0; dma_rdata=0; grant=0.
  - Reset asserted mid-access aborts the access immediately: no ack, strobes drop next edge.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO, ACK.
- IDLE:
  - If any req=1 and sdc_busy=0: pick a winner by the arbitration rule.
  - Latch winner addr, wdata and we into sdc_addr/sdc_data_in; set grant; go to ISSUE.
  - If sdc_busy=1: stay in IDLE.
- ISSUE (exactly 1 cycle): sdc_cs=1; sdc_rd=!we; sdc_wr=we. Go to WAIT_HI.
- WAIT_HI: strobes=0. Stay until sdc_busy=1, then go to WAIT_LO. No timeout.
- WAIT_LO: stay while sdc_busy=1. On sdc_busy=0:
  - For a read, capture sdc_data_out into the owner's rdata.
  - Go to ACK.
- ACK (1 cycle): owner's ack=1; go to IDLE.
- sdc_addr/sdc_data_in are held stable from ISSUE through ACK.
- Latency: req seen in IDLE at edge 0 gives sdc_cs high in cycle 1 and ack in cycle B+3, where B = cycles busy stays high and busy rises the cycle after cs. Minimum request-to-ack is 4 cycles.
- Requester handshake:
  - Requester drops req in the cycle after ack.
  - req still high in the first IDLE cycle after ACK counts as a new request.
- Changes to a non-granted requester's req have no effect until IDLE.
- Fixed priority (default): CPU wins when both requests are high in IDLE.
- The non-owner's rdata is never modified.

Optional Feature:
- Macro: SDC_ARB_ROUND_ROBIN_EN.
- Defined: when both requests are high in IDLE, the winner is the port not granted last time, i.e. the opposite of grant. A single request is granted regardless.
- Undefined: fixed CPU priority as described above.
- No other behaviour changes.

Test Plan:
- CPU read: cpu_req=1, we=0, addr=0x0ABC123; controller raises busy 1 cycle after cs, holds it 3 cycles, data_out=0xDEADBEEF -> one cs+rd pulse with sdc_addr=0x0ABC123; cpu_ack in cycle 6; cpu_rdata=0xDEADBEEF; dma_ack never asserted.
- DMA write: dma_we=1, addr=0x1FFFFFF, wdata=0x12345678 -> sdc_wr pulse 1 cycle; sdc_data_in=0x12345678 held through ACK; dma_ack 1 cycle; grant=1.
- Simultaneous requests, 3 back-to-back rounds, both reqs held:
  - Default: CPU, CPU, CPU.
  - With SDC_ARB_ROUND_ROBIN_EN: CPU, DMA, CPU.
- sdc_busy=1 on entry for 5 cycles with cpu_req=1 -> no cs until the cycle after busy falls.
- Reset asserted during WAIT_LO -> next cycle all strobes/acks=0, state IDLE; busy falling later produces no ack.
- Busy held 20 cycles in WAIT_LO while cpu_req toggles -> sdc_addr/data stable, exactly one ack.
